// File: rtl/twos_comp_pkg.sv
// Shared encodings for the iterative two's-complement unit.
// Holds the operation mode constants and the sequencer state type.
package twos_comp_pkg;

   localparam logic [1:0] MODE_PASS = 2'b00;
   localparam logic [1:0] MODE_NEG  = 2'b01;
   localparam logic [1:0] MODE_ABS  = 2'b10;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

endpackage

// File: rtl/twos_comp_slice.sv
// One CHUNK-wide step of copy-until-first-one-then-invert negation.
// In: chunk_in, flip_in, apply. Out: chunk_out, flip_out.
module twos_comp_slice #(
   parameter int CHUNK = 16
) (
   input  logic [CHUNK-1:0] chunk_in,
   input  logic             flip_in,
   input  logic             apply,
   output logic [CHUNK-1:0] chunk_out,
   output logic             flip_out
);

   logic f;

   // Bits are visited LSB first; flip arms after the first one is copied.
   always_comb begin
      f         = flip_in;
      chunk_out = '0;
      for (int i = 0; i < CHUNK; i++) begin
         chunk_out[i] = (apply && f) ? ~chunk_in[i] : chunk_in[i];
         f            = f | (apply & chunk_in[i]);
      end
      flip_out = f;
   end

endmodule

// File: rtl/twos_comp_iter.sv
// Iterative pass/negate/abs unit, CHUNK bits per cycle, LSB chunk first.
// Ports: clk, clr_n, in_valid/in_ready/in_data/in_mode,
//        out_valid/out_ready/out_data/out_ovf/out_zero.
module twos_comp_iter
   import twos_comp_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int CHUNK = 16
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_ovf,
   output logic             out_zero
);

   localparam int N  = WIDTH / CHUNK;
   localparam int KW = (N > 1) ? $clog2(N) : 1;
   localparam logic [KW-1:0] KLAST = KW'(N - 1);

   if (CHUNK < 1 || WIDTH % CHUNK != 0) begin : g_bad_param
      $error("twos_comp_iter: WIDTH must be a multiple of CHUNK");
   end

   state_t           state;
   logic [KW-1:0]    k;
   logic [WIDTH-1:0] opnd;
   logic             apply;
   logic             flip;
   logic [CHUNK-1:0] chunk_in;
   logic [CHUNK-1:0] chunk_out;
   logic             flip_out;
   logic [WIDTH-1:0] res_nxt;

   assign in_ready  = clr_n && (state == IDLE);
   assign out_valid = (state == DONE);

   always_comb begin
      chunk_in = opnd[int'(k)*CHUNK +: CHUNK];
   end

   // Result with the current chunk merged in; used for the zero flag.
   always_comb begin
      res_nxt = out_data;
      res_nxt[int'(k)*CHUNK +: CHUNK] = chunk_out;
   end

   twos_comp_slice #(
      .CHUNK(CHUNK)
   ) u_slice (
      .chunk_in (chunk_in),
      .flip_in  (flip),
      .apply    (apply),
      .chunk_out(chunk_out),
      .flip_out (flip_out)
   );

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         state    <= IDLE;
         k        <= '0;
         opnd     <= '0;
         apply    <= 1'b0;
         flip     <= 1'b0;
         out_data <= '0;
         out_ovf  <= 1'b0;
         out_zero <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  opnd     <= in_data;
                  apply    <= (in_mode == MODE_NEG) ||
                              ((in_mode == MODE_ABS) && in_data[WIDTH-1]);
                  flip     <= 1'b0;
                  k        <= '0;
                  out_ovf  <= 1'b0;
                  out_zero <= 1'b0;
                  state    <= RUN;
               end
            end
            RUN: begin
               out_data <= res_nxt;
               flip     <= flip_out;
               if (k == KLAST) begin
                  // Sign survives negation only for the most-negative value.
                  out_ovf  <= apply && opnd[WIDTH-1] && chunk_out[CHUNK-1];
                  out_zero <= (res_nxt == '0);
                  k        <= '0;
                  state    <= DONE;
               end else begin
                  k <= k + KW'(1);
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_twos_comp_iter.sv
// Directed bench for twos_comp_iter at WIDTH=64, CHUNK=16.
// Drives on negedge, samples 1ns after posedge.
module tb_twos_comp_iter;

   localparam int WIDTH = 64;
   localparam int CHUNK = 16;
   localparam int N     = WIDTH / CHUNK;

   logic             clk = 1'b0;
   logic             clr_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_data = '0;
   logic [1:0]       in_mode = 2'b00;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] out_data;
   logic             out_ovf;
   logic             out_zero;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   twos_comp_iter #(
      .WIDTH(WIDTH),
      .CHUNK(CHUNK)
   ) dut (
      .clk      (clk),
      .clr_n    (clr_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_mode  (in_mode),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_ovf  (out_ovf),
      .out_zero (out_zero)
   );

   task automatic check(input string tag, input logic [WIDTH-1:0] got,
                        input logic [WIDTH-1:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic start(input string tag, input logic [WIDTH-1:0] d,
                        input logic [1:0] m);
      @(negedge clk);
      check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      in_data  = d;
      in_mode  = m;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      for (int c = 1; c < N; c++) begin
         @(posedge clk);
         #1;
         check({tag, ".early_valid"}, 64'(out_valid), 64'd0);
         check({tag, ".run_ready"}, 64'(in_ready), 64'd0);
      end
      @(posedge clk);
      #1;
      check({tag, ".out_valid"}, 64'(out_valid), 64'd1);
   endtask

   task automatic check_res(input string tag, input logic [WIDTH-1:0] exp,
                            input logic ovf, input logic zero);
      check({tag, ".data"}, out_data, exp);
      check({tag, ".ovf"}, 64'(out_ovf), 64'(ovf));
      check({tag, ".zero"}, 64'(out_zero), 64'(zero));
   endtask

   task automatic handshake(input string tag);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, ".hs_valid"}, 64'(out_valid), 64'd0);
      check({tag, ".hs_ready"}, 64'(in_ready), 64'd1);
   endtask

   task automatic op(input string tag, input logic [WIDTH-1:0] d,
                     input logic [1:0] m, input logic [WIDTH-1:0] exp,
                     input logic ovf, input logic zero);
      start(tag, d, m);
      wait_done(tag);
      check_res(tag, exp, ovf, zero);
      handshake(tag);
   endtask

   initial begin
      logic [WIDTH-1:0] held;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst.in_ready", 64'(in_ready), 64'd0);
      check("rst.out_valid", 64'(out_valid), 64'd0);
      check("rst.out_data", out_data, 64'd0);
      check("rst.ovf", 64'(out_ovf), 64'd0);
      check("rst.zero", 64'(out_zero), 64'd0);
      @(negedge clk);
      clr_n = 1'b1;
      #1;
      check("rst.release_ready", 64'(in_ready), 64'd1);

      // Directed vectors
      op("neg5", 64'h0000_0000_0000_0005, 2'b01,
         64'hFFFF_FFFF_FFFF_FFFB, 1'b0, 1'b0);
      op("neg_c1", 64'h0000_0000_0001_0000, 2'b01,
         64'hFFFF_FFFF_FFFF_0000, 1'b0, 1'b0);
      op("neg0", 64'h0, 2'b01, 64'h0, 1'b0, 1'b1);
      op("abs_m1", 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 64'h1, 1'b0, 1'b0);
      op("abs7", 64'h7, 2'b10, 64'h7, 1'b0, 1'b0);
      op("rsvd", 64'h1234, 2'b11, 64'h1234, 1'b0, 1'b0);
      op("neg_min", 64'h8000_0000_0000_0000, 2'b01,
         64'h8000_0000_0000_0000, 1'b1, 1'b0);
      op("abs_min", 64'h8000_0000_0000_0000, 2'b10,
         64'h8000_0000_0000_0000, 1'b1, 1'b0);
      op("pass_min", 64'h8000_0000_0000_0000, 2'b00,
         64'h8000_0000_0000_0000, 1'b0, 1'b0);

      // Back-pressure in DONE with a stray in_valid
      start("bp", 64'h5, 2'b01);
      wait_done("bp");
      held = out_data;
      check("bp.first", held, 64'hFFFF_FFFF_FFFF_FFFB);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (c == 2) begin
            in_valid = 1'b1;
            in_data  = 64'h3;
            in_mode  = 2'b01;
         end else begin
            in_valid = 1'b0;
         end
         @(posedge clk);
         #1;
         check("bp.data", out_data, held);
         check("bp.valid", 64'(out_valid), 64'd1);
         check("bp.in_ready", 64'(in_ready), 64'd0);
         check("bp.ovf", 64'(out_ovf), 64'd0);
         check("bp.zero", 64'(out_zero), 64'd0);
      end
      in_valid = 1'b0;
      handshake("bp");
      op("bp_next", 64'h1, 2'b01,
         64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);

      // Reset during RUN aborts the operation
      start("abort", 64'h5, 2'b01);
      repeat (2) @(posedge clk);
      @(negedge clk);
      clr_n = 1'b0;
      @(posedge clk);
      #1;
      check("abort.valid", 64'(out_valid), 64'd0);
      check("abort.data", out_data, 64'd0);
      check("abort.in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
      clr_n = 1'b1;
      #1;
      check("abort.release", 64'(in_ready), 64'd1);
      for (int c = 0; c < N + 2; c++) begin
         @(posedge clk);
         #1;
         check("abort.no_result", 64'(out_valid), 64'd0);
      end
      op("after_abort", 64'h2, 2'b01,
         64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/twos_comp_iter.md
# twos_comp_iter

Iterative, parametrised two's-complement unit for the MiniSRC datapath. It applies a negate, an absolute-value or a pass operation to a WIDTH-bit operand, CHUNK bits per cycle, least-significant chunk first. Each chunk uses a copy-until-first-one, then invert rule, and a flip flag carries that state between chunks. The unit sits between the register-file read port and the ALU result mux, behind a valid/ready handshake on both sides. It adds overflow and zero flags and supports back-pressure.

## Interface

Parameters:
- WIDTH, default 64: operand width. Must be divisible by CHUNK.
- CHUNK, default 16: bits processed per cycle, 1 ≤ CHUNK ≤ WIDTH. N = WIDTH/CHUNK.

Ports:
- clk  in  1: the single clock.
- clr_n  in  1: synchronous, active-low reset.
- in_valid  in  1: the operand and mode are valid.
- in_ready  out  1: the unit can accept an operand.
- in_data  in  WIDTH: operand.
- in_mode  in  2: operation select. 00 pass, 01 negate, 10 abs, 11 reserved (treated as pass).
- out_valid  out  1: the result is valid.
- out_ready  in  1: the consumer accepts the result.
- out_data  out  WIDTH: result.
- out_ovf  out  1: result not representable. This is the most-negative value with the negate or abs operation applied.
- out_zero  out  1: out_data == 0.

## Operation

- States are IDLE, RUN and DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: latch in_data and in_mode, clear flip, set chunk counter k = 0, go to RUN.
  - Latch apply = 1 for negate, and for abs when in_data[WIDTH-1] = 1. Otherwise apply = 0.
- RUN, one chunk per cycle, k = 0..N-1:
  - For each bit i of chunk k, ascending: out bit = (apply && flip) ? ~in bit : in bit.
  - Then flip |= in bit (only when apply = 1).
  - The flip value leaving chunk k feeds chunk k+1.
  - After chunk N-1: go to DONE and register out_ovf and out_zero.
  - out_ovf = apply && in_data[WIDTH-1] && out_data[WIDTH-1].
  - in_ready = 0 throughout RUN.
- DONE:
  - out_valid = 1. out_data, out_ovf and out_zero are held stable.
  - On out_ready: go to IDLE. There is no same-cycle accept of a new operand.
- Pass and reserved modes take the same N cycles; latency is uniform across modes.
- in_valid outside IDLE is ignored. The bench must not expect it to be queued.

## Timing

- Reset, clr_n = 0 at a rising edge:
  - State goes to IDLE; out_data = 0, out_valid = 0, out_ovf = 0, out_zero = 0, flip = 0, k = 0.
  - in_ready is forced to 0 while clr_n = 0 and is 1 in the first cycle after release.
- Reset mid-RUN or in DONE aborts the operation. The partial or completed result is never presented.
- Acceptance edge E0: RUN starts. Edges E1..EN process chunks 0..N-1. out_valid is high in the cycle after EN, i.e. N cycles after E0.
- Handshake edge on the output side: state returns to IDLE and in_ready = 1 in the next cycle.
- Minimum throughput is one operation per N+2 cycles.
- During RUN, out_data changes chunk by chunk and is undefined to the consumer until out_valid.
- CHUNK = WIDTH gives N = 1: one RUN cycle.
- A flip set in chunk k inverts every chunk above k, including across every chunk boundary.
- An operand of all zeros never sets flip. The result is 0, with out_zero = 1 and out_ovf = 0.

## Structure

- Package twos_comp_pkg holds:
  - the mode encoding constants (MODE_PASS, MODE_NEG, MODE_ABS);
  - the state enum (IDLE, RUN, DONE).
- Elaboration-time check: WIDTH % CHUNK == 0.
- One sub-module, twos_comp_slice, is combinational:
  - inputs: chunk_in[CHUNK], flip_in, apply;
  - outputs: chunk_out[CHUNK], flip_out.
- The top holds the FSM, counter, operand and result registers, and the flags.

## Test plan

WIDTH=64, CHUNK=16, N=4.
- Negate 0x0000_0000_0000_0005 → 0xFFFF_FFFF_FFFF_FFFB; out_valid exactly 4 cycles after acceptance; ovf=0, zero=0.
- Negate 0x0000_0000_0001_0000 (first one lies in chunk 1) → 0xFFFF_FFFF_FFFF_0000. Then negate 0 → 0 with zero=1, ovf=0.
- Abs 0xFFFF_FFFF_FFFF_FFFF → 0x1. Abs 0x7 → 0x7. Mode 11 on 0x1234 → 0x1234.
- Negate 0x8000_0000_0000_0000 → 0x8000_0000_0000_0000 with ovf=1. Abs of the same value → same result, ovf=1.
- Hold out_ready = 0 for 5 cycles in DONE:
  - out_data and the flags stay stable and in_ready stays 0.
  - A second in_valid in that window is ignored.
  - After the output handshake, the next operand is accepted one cycle later.
- Drive clr_n = 0 after 2 RUN cycles:
  - The next cycle shows out_valid = 0, out_data = 0 and in_ready = 0.
  - in_ready = 1 after release.
  - The aborted result never appears.
